wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that lets NUM_MASTERS Wishbone masters share one Wishbone slave port, for example the I2C core register interface.
- Sits between the master BFMs or CPU-side masters and the single slave.
- The grant is held for the whole bus cycle (cyc high), so block transfers are never interleaved.
- The bus mux is registered-grant and combinational-data: no added latency once a master is granted.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- dwidth, 32, data width; sel width is dwidth/8.
- awidth, 32, address width.
- TIMEOUT_CYCLES, 255, watchdog limit in clocks. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- m_adr_i  in  NUM_MASTERS*awidth  master addresses; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*dwidth  master write data.
- m_sel_i  in  NUM_MASTERS*dwidth/8  master byte selects.
- m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS  per-master cycle, strobe and write-enable.
- m_dat_o  out  dwidth  slave read data, broadcast to all masters.
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS  per-master terminations.
- s_adr_o  out  awidth  slave address.
- s_dat_o  out  dwidth  slave write data.
- s_sel_o  out  dwidth/8  slave byte selects.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave control.
- s_dat_i  in  dwidth  slave read data.
- s_ack_i, s_err_i, s_rty_i  in  1  slave terminations.
- gnt_o  out  NUM_MASTERS  one-hot current grant, for debug and coverage.

Behaviour:
- State machine: two states, IDLE and BUSY, plus register gnt_idx (clog2 NUM_MASTERS) and register last_idx.
- Reset (async, immediate):
  - state=IDLE, gnt_o=0, last_idx=NUM_MASTERS-1, so master 0 has top priority after reset.
  - All s_* outputs are 0, never X.
  - All m_ack/err/rty_o are 0.
- IDLE:
  - The slave sees cyc=stb=we=0 and adr/dat/sel=0.
  - If any m_cyc_i is high, pick the first requester scanning last_idx+1, last_idx+2, ... with wrap-around modulo NUM_MASTERS.
  - On the next posedge: gnt_idx=pick, last_idx=pick, state=BUSY.
  - Grant latency is 1 clock from cyc to s_cyc_o.
- BUSY:
  - s_adr/dat/sel/cyc/stb/we_o follow the granted master's inputs combinationally.
  - The slave's ack/err/rty are routed only to m_*_o[gnt_idx]; all other masters see 0.
  - m_dat_o = s_dat_i always.
- Release: at a posedge where m_cyc_i[gnt_idx]==0, go to IDLE and clear gnt_o.
  - Re-arbitration happens in IDLE the following cycle, giving a one-clock bus turnaround.
  - A master that drops cyc and re-raises it goes behind the other waiting requesters.
- Non-granted masters: requests are only observed. Their stb is ignored, and no termination is ever generated toward them.
- Simultaneous events:
  - All masters requesting: strict rotation 0,1,...,N-1,0.
  - Granted master dropping cyc while others request: release this edge, new grant next edge.
- Reset mid-cycle: the bus is abandoned immediately. s_cyc_o falls asynchronously and no termination is forwarded.
- Slave termination asserted while IDLE: ignored, not forwarded.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter increments each BUSY clock where s_stb_o is high and none of ack/err/rty is high. It clears on any termination or on leaving BUSY.
  - When the counter reaches TIMEOUT_CYCLES, m_err_o[gnt_idx] pulses for one clock, s_stb_o is forced low in that clock, and the counter clears.
  - The grant itself is kept until the master drops cyc.
- Without the macro: no counter logic; err is pure pass-through from the slave.

Decomposition:
- Shared package/include wb_arb_defs:
  - state encodings ARB_IDLE=1'b0, ARB_BUSY=1'b1;
  - MAX_MASTERS=8;
  - clog2 function.
- One sub-module wb_rr_pick: combinational rotating-priority encoder with inputs req[NUM_MASTERS] and last_idx, and outputs pick_idx and any_req. It is reused by other shared-resource blocks.

Test Plan:
- Reset: assert rst mid-simulation with master 1 granted -> s_cyc_o=0 and gnt_o=0 in the same timestep; after release, master 0 is granted first.
- Single master: master 0 writes adr=0x0000_0004, dat=0x0000_00A5 to a 1-wait slave -> s_cyc_o rises 1 clk after m_cyc_i[0]; m_ack_o[0] pulses once; m_ack_o[1]=0 throughout.
- Contention: masters 0 and 1 request in the same clock, each doing 3 back-to-back cycles -> grants alternate 0,1,0,1,0,1 with exactly one idle turnaround clock between owners.
- Block transfer: master 1 holds cyc for 4 reads (0x10..0x1C) while master 0 requests -> master 0 waits until master 1 drops cyc; read data 0x11,0x22,0x33,0x44 is returned in order.
- Termination routing: slave returns rty, then err, to master 2 (NUM_MASTERS=3) -> only m_rty_o[2] and m_err_o[2] pulse; a compare task reports no mismatch.
- WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never acks -> m_err_o[gnt] pulses on the 16th stalled clock. Without the macro, the same stimulus hangs until a bench watchdog expires, which is the expected failure.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter family:
// arbiter state encoding, the supported master count and a constant log2 helper.
package wb_arb_defs;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_MASTERS = 8;

    // Ceiling log2 with a floor of 1 so a 2-master index is still one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Rotating-priority encoder: returns the first asserted request after last_idx_i,
// wrapping modulo NUM_MASTERS. Purely combinational; shared by other arbiters.
module wb_rr_pick
    import wb_arb_defs::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_idx_i,
    output logic [IDX_W-1:0]       pick_idx_o,
    output logic                   any_req_o
);

    int idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick_idx_o = '0;
        idx        = 0;
        // Scan from the farthest candidate down so the nearest requester wins last.
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            idx = (int'(last_idx_i) + off) % NUM_MASTERS;
            if (req_i[idx]) pick_idx_o = IDX_W'(idx);
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave, grant held per bus cycle.
// Optional stalled-strobe watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_defs::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int dwidth         = 32,
    parameter int awidth         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*awidth-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*dwidth-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*dwidth/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    output logic [dwidth-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [NUM_MASTERS-1:0]          m_rty_o,
    output logic [awidth-1:0]               s_adr_o,
    output logic [dwidth-1:0]               s_dat_o,
    output logic [dwidth/8-1:0]             s_sel_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    input  logic [dwidth-1:0]               s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,
    output logic [NUM_MASTERS-1:0]         gnt_o
);

    localparam int SW    = dwidth / 8;
    localparam int IDX_W = clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("wb_rr_arbiter: unsupported parameter set");
    end

    arb_state_e             state_q;
    logic [IDX_W-1:0]       gnt_idx_q;
    logic [IDX_W-1:0]       last_idx_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [IDX_W-1:0]       pick_idx;
    logic                   any_req;
    logic                   busy;
    logic                   owner_cyc;
    logic                   stb_raw;
    logic                   to_hit;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req_i       (m_cyc_i),
        .last_idx_i  (last_idx_q),
        .pick_idx_o  (pick_idx),
        .any_req_o   (any_req)
    );

    assign busy      = (state_q == ARB_BUSY);
    assign owner_cyc = m_cyc_i[gnt_idx_q];

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so the bus drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(NUM_MASTERS - 1);
            gnt_q      <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_req) begin
                        state_q    <= ARB_BUSY;
                        gnt_idx_q  <= pick_idx;
                        last_idx_q <= pick_idx;
                        gnt_q      <= NUM_MASTERS'(1) << pick_idx;
                    end
                end
                ARB_BUSY: begin
                    if (!owner_cyc) begin
                        state_q <= ARB_IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // AND-OR mux on the one-hot grant: all slave-side fields read zero while idle.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_adr_o |= m_adr_i[i*awidth +: awidth] & {awidth{gnt_q[i]}};
            s_dat_o |= m_dat_i[i*dwidth +: dwidth] & {dwidth{gnt_q[i]}};
            s_sel_o |= m_sel_i[i*SW +: SW] & {SW{gnt_q[i]}};
        end
    end

    assign s_cyc_o = |(m_cyc_i & gnt_q);
    assign s_we_o  = |(m_we_i & gnt_q);
    assign stb_raw = |(m_stb_i & gnt_q);
    assign s_stb_o = stb_raw & ~to_hit;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO_W = 16;

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            term;
    logic            stall;

    assign term   = s_ack_i | s_err_i | s_rty_i;
    assign stall  = busy & stb_raw & ~term;
    assign to_hit = stall & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!busy || !owner_cyc || term || to_hit) to_cnt_d = '0;
        else if (stall)                            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign m_ack_o = gnt_q & {NUM_MASTERS{s_ack_i}};
    assign m_err_o = gnt_q & {NUM_MASTERS{s_err_i | to_hit}};
    assign m_rty_o = gnt_q & {NUM_MASTERS{s_rty_i}};
    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed bus scenarios plus randomized traffic,
// every cycle compared against a behavioural grant/ownership model.
module tb_wb_rr_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, gnt_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack_i, s_err_i, s_rty_i;

    wb_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .dwidth         (DW),
        .awidth         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .gnt_o   (gnt_o)
    );

    // Per-master drive state, packed onto the DUT buses.
    logic          mcyc [NM];
    logic          mstb [NM];
    logic          mwe  [NM];
    logic [AW-1:0] madr [NM];
    logic [DW-1:0] mdat [NM];
    logic [SW-1:0] msel [NM];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_cyc_i[i]           = mcyc[i];
            m_stb_i[i]           = mstb[i];
            m_we_i[i]            = mwe[i];
            m_adr_i[i*AW +: AW]  = madr[i];
            m_dat_i[i*DW +: DW]  = mdat[i];
            m_sel_i[i*SW +: SW]  = msel[i];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who won last, how long the owner has stalled.
    int own   = -1;
    int last  = NM - 1;
    int stall = 0;

    function automatic bit to_hit_now();
`ifdef WB_ARB_TIMEOUT_EN
        return own >= 0 && mstb[own] && !(s_ack_i || s_err_i || s_rty_i) && stall == TO - 1;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            own = -1; last = NM - 1; stall = 0;
        end else if (own < 0) begin
            bit found;
            found = 1'b0;
            stall = 0;
            for (int k = 1; k <= NM; k++) begin
                if (!found && mcyc[(last + k) % NM]) begin
                    found = 1'b1;
                    own   = (last + k) % NM;
                end
            end
            if (found) last = own;
        end else begin
            if (!mcyc[own])                                          begin own = -1; stall = 0; end
            else if (s_ack_i || s_err_i || s_rty_i || to_hit_now())  stall = 0;
            else if (mstb[own])                                      stall++;
        end
    end

    int ack_cnt [NM];
    int term_cnt[NM];

    always @(negedge clk) begin : cmp
        logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
        logic          e_cyc, e_stb, e_we, hit;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        if (!rst) begin
            e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
            e_cyc = 0; e_stb = 0; e_we = 0; hit = 0;
            e_adr = '0; e_dat = '0; e_sel = '0;
            if (own >= 0) begin
                hit        = to_hit_now();
                e_gnt[own] = 1'b1;
                e_cyc      = mcyc[own];
                e_stb      = mstb[own] && !hit;
                e_we       = mwe[own];
                e_adr      = madr[own];
                e_dat      = mdat[own];
                e_sel      = msel[own];
                e_ack[own] = s_ack_i;
                e_err[own] = s_err_i || hit;
                e_rty[own] = s_rty_i;
            end
            check("gnt",   gnt_o, e_gnt);
            check("s_ctl", {s_cyc_o, s_stb_o, s_we_o}, {e_cyc, e_stb, e_we});
            check("s_adr", s_adr_o, e_adr);
            check("s_dat", s_dat_o, e_dat);
            check("s_sel", s_sel_o, e_sel);
            check("m_term", {m_ack_o, m_err_o, m_rty_o}, {e_ack, e_err, e_rty});
            check("m_dat", m_dat_o, s_dat_i);
            for (int i = 0; i < NM; i++) begin
                if (m_ack_o[i])              ack_cnt[i]++;
                if (m_err_o[i] | m_rty_o[i]) term_cnt[i]++;
            end
        end
    end

    // Grant log: owner sequence and idle clocks preceding each new grant.
    int            glog[$];
    int            gap_log[$];
    int            idle_run = 0;
    logic [NM-1:0] prev_gnt = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_gnt = '0; idle_run = 0;
        end else begin
            if (gnt_o != '0 && prev_gnt == '0) begin
                for (int i = 0; i < NM; i++) if (gnt_o[i]) glog.push_back(i);
                gap_log.push_back(idle_run);
                idle_run = 0;
            end else if (gnt_o == '0) begin
                idle_run++;
            end
            prev_gnt = gnt_o;
        end
    end

    // Registered slave: one wait state, then a single-clock termination of the chosen kind.
    bit            slave_en   = 1'b1;
    int            slave_term = 0;
    int            wcnt       = 0;
    logic          plan       = 1'b0;
    logic [DW-1:0] plan_dat   = '0;
    logic [AW-1:0] wr_adr     = '0;
    logic [DW-1:0] wr_dat     = '0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    always @(negedge clk) begin
        if (slave_en) begin
            if (s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i)) begin
                wcnt++;
                plan = (wcnt >= 1);
            end else begin
                wcnt = 0;
                plan = 1'b0;
            end
            if (plan) begin
                plan_dat = mem.exists(s_adr_o) ? mem[s_adr_o] : '0;
                if (s_we_o) begin wr_adr = s_adr_o; wr_dat = s_dat_o; end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (slave_en) begin
            s_ack_i = plan && slave_term == 0;
            s_err_i = plan && slave_term == 1;
            s_rty_i = plan && slave_term == 2;
            s_dat_i = plan ? plan_dat : '0;
        end
    end

    logic [DW-1:0] rd_q[$];

    // One master bus cycle of n transfers; returns the last termination kind (0 ack, 1 err, 2 rty).
    task automatic mcycle(input int m, input int n, input bit we,
                          input logic [AW-1:0] adr0, input logic [DW-1:0] dat0, output int kind);
        bit done;
        kind    = -1;
        mcyc[m] = 1'b1;
        mwe[m]  = we;
        msel[m] = '1;
        for (int i = 0; i < n; i++) begin
            madr[m] = adr0 + AW'(4 * i);
            mdat[m] = dat0 + DW'(i);
            mstb[m] = 1'b1;
            done    = 1'b0;
            for (int b = 0; b < 60 && !done; b++) begin
                @(negedge clk);
                if (m_ack_o[m] || m_err_o[m] || m_rty_o[m]) begin
                    done = 1'b1;
                    kind = m_ack_o[m] ? 0 : (m_err_o[m] ? 1 : 2);
                    if (!we) rd_q.push_back(m_dat_o);
                end
                @(posedge clk); #1;
            end
            check($sformatf("term_wait_m%0d", m), done, 1);
            mstb[m] = 1'b0;
        end
        mcyc[m] = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [DW-1:0] exp_rd [4];

    initial begin
        int k0, k1, stalled;
        bit seen;

        exp_rd = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) mem[AW'(32'h10 + 4 * i)] = exp_rd[i];
        for (int i = 0; i < NM; i++) begin
            mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; madr[i] = '0; mdat[i] = '0; msel[i] = '0;
            ack_cnt[i] = 0; term_cnt[i] = 0;
        end
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt_o, 0);
        check("rst_sbus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o}, 0);
        check("rst_term", {m_ack_o, m_err_o, m_rty_o}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single master write through a one-wait slave
        fork
            mcycle(0, 1, 1'b1, 32'h4, 32'hA5, k0);
            begin
                @(negedge clk); check("lat_before", s_cyc_o, 0);
                @(negedge clk); check("lat_one",    s_cyc_o, 1);
            end
        join
        check("single_ack0", ack_cnt[0], 1);
        check("single_ack1", ack_cnt[1], 0);
        check("single_adr",  wr_adr, 32'h4);
        check("single_dat",  wr_dat, 32'hA5);

        // Reset while master 1 owns the bus
        mcyc[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_gnt", gnt_o, 3'b010);
        check("pre_rst_cyc", s_cyc_o, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_cyc", s_cyc_o, 0);
        check("mid_rst_gnt", gnt_o, 0);
        mcyc[1] = 1'b0;
        glog.delete(); gap_log.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Contention: masters 0 and 1, three bus cycles each, same starting clock
        fork
            begin repeat (3) mcycle(0, 1, 1'b1, 32'h100, 32'h1, k0); end
            begin repeat (3) mcycle(1, 1, 1'b1, 32'h180, 32'h2, k1); end
        join
        check("rr_count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) begin
            check($sformatf("rr_order%0d", i), glog[i], i % 2);
            if (i > 0) check($sformatf("rr_gap%0d", i), gap_log[i], 1);
        end

        // Block read by master 1 while master 0 waits
        glog.delete(); gap_log.delete(); rd_q.delete();
        fork
            mcycle(1, 4, 1'b0, 32'h10, 32'h0, k1);
            begin @(posedge clk); #1; mcycle(0, 1, 1'b1, 32'h200, 32'h5, k0); end
        join
        check("blk_count", glog.size(), 2);
        if (glog.size() == 2) begin
            check("blk_first",  glog[0], 1);
            check("blk_second", glog[1], 0);
        end
        check("blk_rd_count", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check($sformatf("blk_rd%0d", i), rd_q[i], exp_rd[i]);

        // Termination routing to master 2
        for (int i = 0; i < NM; i++) term_cnt[i] = 0;
        slave_term = 2;
        mcycle(2, 1, 1'b1, 32'h300, 32'h7, k0);
        check("route_rty_kind", k0, 2);
        slave_term = 1;
        mcycle(2, 1, 1'b0, 32'h304, 32'h0, k1);
        check("route_err_kind", k1, 1);
        slave_term = 0;
        check("route_m2", term_cnt[2], 2);
        check("route_others", term_cnt[0] + term_cnt[1], 0);

        // Slave that never terminates
        slave_en = 1'b0;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h40;
        seen = 1'b0; stalled = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (s_cyc_o) begin
                stalled++;
                if (m_err_o[0]) seen = 1'b1;
            end
        end
`ifdef WB_ARB_TIMEOUT_EN
        check("to_seen",  seen, 1);
        check("to_clock", stalled, TO);
`else
        check("to_none",  seen, 0);
`endif
        @(posedge clk); #1;
        mcyc[0] = 1'b0; mstb[0] = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, 5) == 0) mcyc[i] = ~mcyc[i];
                mstb[i] = 1'($urandom);
                mwe[i]  = 1'($urandom);
                madr[i] = $urandom;
                mdat[i] = $urandom;
                msel[i] = SW'($urandom);
            end
            s_ack_i = ($urandom_range(0, 5) == 0);
            s_err_i = ($urandom_range(0, 11) == 0);
            s_rty_i = ($urandom_range(0, 11) == 0);
            s_dat_i = $urandom;
            @(posedge clk); #1;
        end
        for (int i = 0; i < NM; i++) begin mcyc[i] = 0; mstb[i] = 0; end
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
